nes_pad_responder: RTL and testbench

NES_PAD_RESPONDER -- requirements
Module: nes_pad_responder

---
 rtl/nes_pkg.sv | 30 +++
 rtl/nes_sync_edge.sv | 39 +++
 rtl/nes_pad_responder.sv | 142 ++++++++++++++
 tb/tb_nes_pad_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_pkg.sv
// ============================================================================
// Module : nes_pkg
// Shared state encoding, button bit indices and defaults for the NES pad responder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package nes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } nes_state_e;

  localparam int BTN_A    = 0;
  localparam int BTN_B    = 1;
  localparam int BTN_SEL  = 2;
  localparam int BTN_STRT = 3;
  localparam int BTN_UP   = 4;
  localparam int BTN_DN   = 5;
  localparam int BTN_L    = 6;
  localparam int BTN_R    = 7;

  localparam int DEFAULT_TIMEOUT_CYC = 50000;

endpackage

`default_nettype wire

// File: rtl/nes_sync_edge.sv
// ============================================================================
// Module : nes_sync_edge
// N-stage synchronizer for an asynchronous input, with rise/fall edge strobes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module nes_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              dly;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
      dly  <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      dly  <= sync[STAGES-1];
    end
  end

  // Edges compare the last synchronized stage against one extra delay flop.
  assign level = sync[STAGES-1];
  assign rise  = sync[STAGES-1] & ~dly;
  assign fall  = ~sync[STAGES-1] & dly;

endmodule

`default_nettype wire

// File: rtl/nes_pad_responder.sv
// ============================================================================
// Module : nes_pad_responder
// Emulates an NES controller: latches buttons on the console strobe, shifts them out.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module nes_pad_responder
  import nes_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] buttons,
  input  logic       latch_in,
  input  logic       pulse_in,
  output logic       data_out,
  output logic       frame_done,
  output logic [7:0] frame_cnt
);

  localparam int              TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0]   TO_ONE  = TW'(1);

  nes_state_e    state;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic [TW-1:0] to_cnt;
  logic [7:0]    shifted;

  logic latch_lvl, latch_rise, latch_fall;
  logic pulse_lvl, pulse_rise, pulse_fall;
  logic unused_sync;

  nes_sync_edge #(.STAGES(SYNC_STAGES)) u_latch_sync (
    .clk   (clk),
    .reset (reset),
    .din   (latch_in),
    .level (latch_lvl),
    .rise  (latch_rise),
    .fall  (latch_fall)
  );

  nes_sync_edge #(.STAGES(SYNC_STAGES)) u_pulse_sync (
    .clk   (clk),
    .reset (reset),
    .din   (pulse_in),
    .level (pulse_lvl),
    .rise  (pulse_rise),
    .fall  (pulse_fall)
  );

  assign unused_sync = pulse_lvl ^ pulse_fall;
  assign shifted     = {1'b0, shreg[7:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      data_out   <= 1'b1;
      frame_done <= 1'b0;
      frame_cnt  <= 8'd0;
      shreg      <= 8'hFF;
      bit_cnt    <= 3'd0;
      to_cnt     <= '0;
    end else begin
      frame_done <= 1'b0;
      if (!en) begin
        state    <= ST_IDLE;
        data_out <= 1'b1;
        bit_cnt  <= 3'd0;
        to_cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            data_out <= 1'b1;
            if (latch_rise) begin
              state    <= ST_LATCH;
              shreg    <= ~buttons;
              data_out <= ~buttons[BTN_A];
              bit_cnt  <= 3'd0;
            end
          end
          ST_LATCH: begin
            if (latch_fall) begin
              state    <= ST_SHIFT;
              data_out <= shreg[0];
              to_cnt   <= '0;
            end else if (latch_lvl) begin
              shreg    <= ~buttons;
              data_out <= ~buttons[BTN_A];
              bit_cnt  <= 3'd0;
            end
          end
          ST_SHIFT: begin
            // A latch rise wins over a coincident pulse rise.
            if (latch_rise) begin
              state    <= ST_LATCH;
              shreg    <= ~buttons;
              data_out <= ~buttons[BTN_A];
              bit_cnt  <= 3'd0;
              to_cnt   <= '0;
            end else if (pulse_rise) begin
              shreg    <= shifted;
              data_out <= shifted[0];
              bit_cnt  <= bit_cnt + 3'd1;
              to_cnt   <= '0;
              if (bit_cnt == 3'd7) begin
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + 8'd1;
                state      <= ST_DONE;
                data_out   <= 1'b0;
              end
            end else if (to_cnt == TO_LAST) begin
              state    <= ST_IDLE;
              data_out <= 1'b1;
              to_cnt   <= '0;
            end else begin
              to_cnt <= to_cnt + TO_ONE;
            end
          end
          ST_DONE: begin
            data_out <= 1'b0;
            if (latch_rise) begin
              state    <= ST_LATCH;
              shreg    <= ~buttons;
              data_out <= ~buttons[BTN_A];
              bit_cnt  <= 3'd0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nes_pad_responder.sv
// ============================================================================
// Module : tb_nes_pad_responder
// Directed self-checking bench for nes_pad_responder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_nes_pad_responder;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b1;
  logic [7:0] buttons = 8'h00;
  logic       latch_in = 1'b0;
  logic       pulse_in = 1'b0;
  logic       data_out;
  logic       frame_done;
  logic [7:0] frame_cnt;

  int total = 0;
  int bad = 0;
  int done_seen = 0;
  int exp_cnt = 0;

  nes_pad_responder #(.SYNC_STAGES(2), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .buttons    (buttons),
    .latch_in   (latch_in),
    .pulse_in   (pulse_in),
    .data_out   (data_out),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) done_seen++;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse();
    pulse_in = 1'b1;
    cyc(3);
    pulse_in = 1'b0;
    cyc(3);
  endtask

  task automatic latch_frame();
    latch_in = 1'b1;
    cyc(4);
    latch_in = 1'b0;
    cyc(4);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(2);
    total++; if (data_out !== 1'b1) begin bad++; $display("FAIL reset_data_out got=%b want=1", data_out); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
    total++; if (frame_cnt !== 8'd0) begin bad++; $display("FAIL reset_frame_cnt got=%0d want=0", frame_cnt); end
    reset = 1'b0;
    cyc(2);
  endtask

  task automatic test_basic();
    logic [7:0] want;
    int d0;
    want = 8'b1111_1010;
    d0 = done_seen;
    buttons = 8'h05;
    latch_in = 1'b1;
    cyc(4);
    total++; if (data_out !== 1'b0) begin bad++; $display("FAIL basic_latch_a got=%b want=0", data_out); end
    buttons = 8'h04;
    cyc(1);
    total++; if (data_out !== 1'b1) begin bad++; $display("FAIL basic_latch_live got=%b want=1", data_out); end
    buttons = 8'h05;
    cyc(1);
    latch_in = 1'b0;
    cyc(4);
    total++; if (data_out !== 1'b0) begin bad++; $display("FAIL basic_bit0 got=%b want=0", data_out); end
    for (int k = 1; k <= 8; k++) begin
      pulse();
      total++;
      if (data_out !== ((k < 8) ? want[k] : 1'b0)) begin
        bad++; $display("FAIL basic_bit%0d got=%b want=%b", k, data_out, (k < 8) ? want[k] : 1'b0);
      end
    end
    exp_cnt++;
    total++; if (done_seen - d0 != 1) begin bad++; $display("FAIL basic_done_pulses got=%0d want=1", done_seen - d0); end
    total++; if (frame_cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL basic_frame_cnt got=%0d want=%0d", frame_cnt, exp_cnt); end
    pulse();
    total++; if (data_out !== 1'b0) begin bad++; $display("FAIL basic_done_extra got=%b want=0", data_out); end
    total++; if (frame_cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL basic_done_cnt got=%0d want=%0d", frame_cnt, exp_cnt); end
  endtask

  task automatic test_abort();
    int d0;
    d0 = done_seen;
    buttons = 8'h01;
    latch_frame();
    repeat (3) pulse();
    buttons = 8'h00;
    latch_in = 1'b1;
    cyc(4);
    total++; if (data_out !== 1'b1) begin bad++; $display("FAIL abort_live got=%b want=1", data_out); end
    total++; if (frame_cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL abort_cnt got=%0d want=%0d", frame_cnt, exp_cnt); end
    total++; if (done_seen != d0) begin bad++; $display("FAIL abort_done got=%0d want=%0d", done_seen, d0); end
    latch_in = 1'b0;
    cyc(4);
    repeat (8) pulse();
    exp_cnt++;
    total++; if (frame_cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL abort_refill_cnt got=%0d want=%0d", frame_cnt, exp_cnt); end
  endtask

  task automatic test_hold();
    buttons = 8'h00;
    latch_frame();
    cyc(2);
    buttons = 8'hFF;
    total++; if (data_out !== 1'b1) begin bad++; $display("FAIL hold_bit0 got=%b want=1", data_out); end
    for (int k = 1; k <= 7; k++) begin
      pulse();
      total++; if (data_out !== 1'b1) begin bad++; $display("FAIL hold_bit%0d got=%b want=1", k, data_out); end
    end
    pulse();
    exp_cnt++;
    total++; if (data_out !== 1'b0) begin bad++; $display("FAIL hold_after8 got=%b want=0", data_out); end
    total++; if (frame_cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL hold_cnt got=%0d want=%0d", frame_cnt, exp_cnt); end
  endtask

  task automatic test_timeout();
    int d0;
    d0 = done_seen;
    buttons = 8'h01;
    latch_frame();
    cyc(18);
    total++; if (data_out !== 1'b0) begin bad++; $display("FAIL timeout_early got=%b want=0", data_out); end
    cyc(1);
    total++; if (data_out !== 1'b1) begin bad++; $display("FAIL timeout_idle got=%b want=1", data_out); end
    pulse();
    total++; if (data_out !== 1'b1) begin bad++; $display("FAIL timeout_pulse_idle got=%b want=1", data_out); end
    total++; if (frame_cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL timeout_cnt got=%0d want=%0d", frame_cnt, exp_cnt); end
    total++; if (done_seen != d0) begin bad++; $display("FAIL timeout_done got=%0d want=%0d", done_seen, d0); end
  endtask

  task automatic test_enable();
    int d0;
    d0 = done_seen;
    buttons = 8'hFF;
    latch_frame();
    repeat (2) pulse();
    total++; if (data_out !== 1'b0) begin bad++; $display("FAIL en_shift got=%b want=0", data_out); end
    en = 1'b0;
    cyc(1);
    total++; if (data_out !== 1'b1) begin bad++; $display("FAIL en_off got=%b want=1", data_out); end
    repeat (8) pulse();
    total++; if (data_out !== 1'b1) begin bad++; $display("FAIL en_pulses got=%b want=1", data_out); end
    total++; if (frame_cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL en_cnt got=%0d want=%0d", frame_cnt, exp_cnt); end
    total++; if (done_seen != d0) begin bad++; $display("FAIL en_done got=%0d want=%0d", done_seen, d0); end
    en = 1'b1;
    cyc(2);
    pulse();
    total++; if (data_out !== 1'b1) begin bad++; $display("FAIL en_back_idle got=%b want=1", data_out); end
  endtask

  task automatic test_simultaneous();
    int d0;
    buttons = 8'h01;
    latch_frame();
    repeat (3) pulse();
    d0 = done_seen;
    latch_in = 1'b1;
    pulse_in = 1'b1;
    cyc(4);
    total++; if (data_out !== 1'b0) begin bad++; $display("FAIL simul_latch got=%b want=0", data_out); end
    pulse_in = 1'b0;
    latch_in = 1'b0;
    cyc(4);
    repeat (7) pulse();
    total++; if (frame_cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL simul_7_cnt got=%0d want=%0d", frame_cnt, exp_cnt); end
    total++; if (data_out !== 1'b1) begin bad++; $display("FAIL simul_bit7 got=%b want=1", data_out); end
    pulse();
    exp_cnt++;
    total++; if (frame_cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL simul_8_cnt got=%0d want=%0d", frame_cnt, exp_cnt); end
    total++; if (done_seen - d0 != 1) begin bad++; $display("FAIL simul_done got=%0d want=1", done_seen - d0); end
  endtask

  task automatic test_wrap();
    int n;
    n = 256 - (exp_cnt % 256);
    buttons = 8'h3C;
    for (int f = 0; f < n; f++) begin
      latch_frame();
      repeat (8) pulse();
      exp_cnt = (exp_cnt + 1) % 256;
      if (f == n - 2) begin
        total++; if (frame_cnt !== 8'd255) begin bad++; $display("FAIL wrap_255 got=%0d want=255", frame_cnt); end
      end
    end
    total++; if (frame_cnt !== 8'd0) begin bad++; $display("FAIL wrap_0 got=%0d want=0", frame_cnt); end
  endtask

  task automatic test_reset_mid();
    int d0;
    buttons = 8'hFF;
    latch_frame();
    repeat (8) pulse();
    exp_cnt++;
    total++; if (frame_cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL rmid_pre_cnt got=%0d want=%0d", frame_cnt, exp_cnt); end
    latch_frame();
    repeat (3) pulse();
    total++; if (data_out !== 1'b0) begin bad++; $display("FAIL rmid_shift got=%b want=0", data_out); end
    d0 = done_seen;
    #2 reset = 1'b1;
    #1;
    total++; if (data_out !== 1'b1) begin bad++; $display("FAIL rmid_data_out got=%b want=1", data_out); end
    total++; if (frame_cnt !== 8'd0) begin bad++; $display("FAIL rmid_cnt got=%0d want=0", frame_cnt); end
    cyc(2);
    reset = 1'b0;
    exp_cnt = 0;
    repeat (8) pulse();
    total++; if (data_out !== 1'b1) begin bad++; $display("FAIL rmid_wait_latch got=%b want=1", data_out); end
    total++; if (done_seen != d0) begin bad++; $display("FAIL rmid_done got=%0d want=%0d", done_seen, d0); end
    total++; if (frame_cnt !== 8'd0) begin bad++; $display("FAIL rmid_cnt_after got=%0d want=0", frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_abort();
    test_hold();
    test_timeout();
    test_enable();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
